// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Radix-2 shift-add multiply, restoring divide, one bit per cycle.
module muldiv_sequencer #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [DATA_BITS-1:0] OpA,
  input  logic [DATA_BITS-1:0] OpB,
  input  logic                 Flush,
  input  logic                 HiWe,
  input  logic                 LoWe,
  input  logic [DATA_BITS-1:0] WrData,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATA_BITS-1:0] Hi,
  output logic [DATA_BITS-1:0] Lo
);

  localparam int W  = DATA_BITS;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic           dz;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] prod;

  logic         sa;
  logic         sb;
  logic [W-1:0] ma;
  logic [W-1:0] mb;

  assign sa = Op[0] & OpA[W-1];
  assign sb = Op[0] & OpB[W-1];
  assign ma = sa ? -OpA : OpA;
  assign mb = sb ? -OpB : OpB;

  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic [W:0]     div_trial;
  logic [2*W-1:0] step_next;

  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, a & {W{prod[0]}}};
    div_sh    = {prod[2*W-1:W], prod[W-1]};
    div_trial = div_sh - {1'b0, b};
    step_next = {mul_sum, prod[W-1:1]};
    if (is_div) begin
      // A borrow out of the trial subtract means the divisor did not fit.
      if (div_trial[W])
        step_next = {div_sh[W-1:0], prod[W-2:0], 1'b0};
      else
        step_next = {div_trial[W-1:0], prod[W-2:0], 1'b1};
    end
  end

  logic [2*W-1:0] res;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;

  always_comb begin
    res    = neg_q ? -prod : prod;
    fix_hi = res[2*W-1:W];
    fix_lo = res[W-1:0];
    if (is_div) begin
      if (dz) begin
        fix_lo = '1;
        fix_hi = neg_r ? -a : a;
      end else begin
        fix_lo = neg_q ? -prod[W-1:0] : prod[W-1:0];
        fix_hi = neg_r ? -prod[2*W-1:W] : prod[2*W-1:W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a      <= '0;
      b      <= '0;
      prod   <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (HiWe) Hi <= WrData;
          if (LoWe) Lo <= WrData;
          if (Start && !Flush) begin
            state  <= RUN;
            Busy   <= 1'b1;
            cnt    <= '0;
            is_div <= Op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= Op[1] & (OpB == '0);
            a      <= ma;
            b      <= mb;
            prod   <= {{W{1'b0}}, Op[1] ? ma : mb};
          end
        end
        RUN: begin
          if (Flush) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            prod <= step_next;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (!Flush) begin
            Hi   <= fix_hi;
            Lo   <= fix_lo;
            Done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic model.
// Random and directed ops, flush, reset abort, busy-ignore, back-to-back.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Flush;
  logic        HiWe;
  logic        LoWe;
  logic [31:0] WrData;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad = 0;
  int busy_cnt;
  int done_cyc;
  int done_cnt;

  always #5 clk = ~clk;

  muldiv_sequencer #(.DATA_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op),
    .OpA(OpA), .OpB(OpB), .Flush(Flush), .HiWe(HiWe),
    .LoWe(LoWe), .WrData(WrData), .Busy(Busy), .Done(Done),
    .Hi(Hi), .Lo(Lo)
  );

  function automatic void model(
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] hi,
    output logic [31:0] lo
  );
    longint sx;
    longint sy;
    logic [63:0] p;
    sx = op[0] ? longint'($signed(x)) : longint'(x);
    sy = op[0] ? longint'($signed(y)) : longint'(y);
    if (!op[1]) begin
      p  = 64'(sx * sy);
      hi = p[63:32];
      lo = p[31:0];
    end else if (y == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = x;
    end else begin
      p  = 64'(sx / sy);
      lo = p[31:0];
      p  = 64'(sx % sy);
      hi = p[31:0];
    end
  endfunction

  // Launch one op, scramble operands after accept, observe 40 cycles.
  task automatic run_op(input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y);
    @(negedge clk);
    Start = 1'b1;
    Op    = op;
    OpA   = x;
    OpB   = y;
    @(posedge clk);
    #1;
    Start = 1'b0;
    OpA   = $urandom;
    OpB   = $urandom;
    busy_cnt = 0;
    done_cyc = 0;
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0;
    Flush = 1'b0; HiWe = 1'b0; LoWe = 1'b0; WrData = '0;
    repeat (3) @(negedge clk);
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               Busy, Done, Hi, Lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic [1:0]  ops [3] = '{2'b00, 2'b01, 2'b01};
    logic [31:0] xs  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] ys  [3] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
    logic [31:0] eh;
    logic [31:0] el;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], xs[i], ys[i]);
      model(ops[i], xs[i], ys[i], eh, el);
      total++;
      if (Hi !== eh || Lo !== el) begin
        bad++;
        $display("FAIL mult%0d: hi=%h lo=%h want hi=%h lo=%h",
                 i, Hi, Lo, eh, el);
      end
      total++;
      if (busy_cnt != 33 || done_cyc != 34 || done_cnt != 1) begin
        bad++;
        $display("FAIL mult%0d_timing: busy=%0d done@%0d n=%0d want 33 34 1",
                 i, busy_cnt, done_cyc, done_cnt);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [4] = '{2'b11, 2'b10, 2'b11, 2'b11};
    logic [31:0] xs  [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000,
                             32'hFFFF_FFF9};
    logic [31:0] ys  [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh;
    logic [31:0] el;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i]);
      model(ops[i], xs[i], ys[i], eh, el);
      total++;
      if (Hi !== eh || Lo !== el) begin
        bad++;
        $display("FAIL div%0d: hi=%h lo=%h want hi=%h lo=%h",
                 i, Hi, Lo, eh, el);
      end
      total++;
      if (busy_cnt != 33 || done_cyc != 34) begin
        bad++;
        $display("FAIL div%0d_timing: busy=%0d done@%0d want 33 34",
                 i, busy_cnt, done_cyc);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i % 6 == 1) x = 32'($urandom_range(0, 300));
      run_op(op, x, y);
      model(op, x, y, eh, el);
      total++;
      if (Hi !== eh || Lo !== el || done_cyc != 34) begin
        bad++;
        $display("FAIL rand%0d op=%0d %h,%h: hi=%h lo=%h done@%0d want %h %h 34",
                 i, op, x, y, Hi, Lo, done_cyc, eh, el);
      end
    end
  endtask

  task automatic test_flush();
    int dn;
    @(negedge clk);
    HiWe = 1'b1; WrData = 32'h11;
    @(negedge clk);
    HiWe = 1'b0; LoWe = 1'b1; WrData = 32'h22;
    @(negedge clk);
    LoWe = 1'b0;
    total++;
    if (Hi !== 32'h11 || Lo !== 32'h22) begin
      bad++;
      $display("FAIL mt_write: hi=%h lo=%h want 11 22", Hi, Lo);
    end
    Start = 1'b1; Op = 2'b00; OpA = 32'd5; OpB = 32'd6;
    @(posedge clk);
    #1 Start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre_busy: busy=%b want 1", Busy);
    end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_busy: busy=%b want 0", Busy);
    end
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (Done) dn++;
    end
    total++;
    if (dn != 0 || Hi !== 32'h11 || Lo !== 32'h22) begin
      bad++;
      $display("FAIL flush_result: dones=%0d hi=%h lo=%h want 0 11 22",
               dn, Hi, Lo);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
    x = $urandom;
    y = $urandom;
    model(2'b01, x, y, eh, el);
    @(negedge clk);
    Start = 1'b1; Op = 2'b01; OpA = x; OpB = y;
    @(posedge clk);
    #1 Start = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (Done && done_cyc == 0) done_cyc = c;
      Start = (c == 5);
      HiWe  = (c == 5);
      if (c == 5) begin
        Op = 2'b10; OpA = $urandom; OpB = $urandom; WrData = 32'hDEAD_BEEF;
      end
    end
    total++;
    if (Hi !== eh || Lo !== el) begin
      bad++;
      $display("FAIL busy_ignore: hi=%h lo=%h want %h %h", Hi, Lo, eh, el);
    end
    total++;
    if (busy_cnt != 33 || done_cyc != 34) begin
      bad++;
      $display("FAIL busy_ignore_timing: busy=%0d done@%0d want 33 34",
               busy_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1;
    logic [31:0] y1;
    logic [31:0] x2;
    logic [31:0] y2;
    logic [31:0] eh;
    logic [31:0] el;
    x1 = $urandom; y1 = 32'($urandom_range(1, 1000));
    x2 = $urandom; y2 = $urandom;
    @(negedge clk);
    Start = 1'b1; Op = 2'b10; OpA = x1; OpB = y1;
    @(posedge clk);
    #1 Start = 1'b0;
    for (int c = 1; c <= 34; c++) @(negedge clk);
    model(2'b10, x1, y1, eh, el);
    total++;
    if (Done !== 1'b1 || Hi !== eh || Lo !== el) begin
      bad++;
      $display("FAIL b2b_first: done=%b hi=%h lo=%h want 1 %h %h",
               Done, Hi, Lo, eh, el);
    end
    Start = 1'b1; Op = 2'b00; OpA = x2; OpB = y2;
    @(posedge clk);
    #1 Start = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (Done && done_cyc == 0) done_cyc = c;
    end
    model(2'b00, x2, y2, eh, el);
    total++;
    if (Hi !== eh || Lo !== el || busy_cnt != 33 || done_cyc != 34) begin
      bad++;
      $display("FAIL b2b_second: hi=%h lo=%h busy=%0d done@%0d want %h %h 33 34",
               Hi, Lo, busy_cnt, done_cyc, eh, el);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    int bz;
    @(negedge clk);
    Start = 1'b1; Op = 2'b10; OpA = 32'd1000; OpB = 32'd7;
    @(posedge clk);
    #1 Start = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               Busy, Done, Hi, Lo);
    end
    rst_n = 1'b1;
    dn = 0;
    bz = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Done) dn++;
      if (Busy) bz++;
    end
    total++;
    if (dn != 0 || bz != 0 || Hi !== 32'd0 || Lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_after: dones=%0d busy=%0d hi=%h lo=%h want 0 0 0 0",
               dn, bz, Hi, Lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_flush();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
